dual_port_hamming_ram: RTL and testbench

Dual-port synchronous RAM with independent read and write latency per port. Words are stored Hamming-encoded and single-bit errors are corrected on read. Storage is split into two address-interleaved banks. The block is the memory core under the dual-port test environment, with one port interface per side (A, B).

---
 rtl/dual_port_hamming_ram_pkg.sv | 65 ++++++
 rtl/dual_port_hamming_ram_ram_port_pipe.sv | 127 ++++++++++++
 rtl/dual_port_hamming_ram.sv | 85 ++++++++
 tb/tb_dual_port_hamming_ram.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dual_port_hamming_ram_pkg.sv
// Shared definitions for the dual-port Hamming RAM: parameter defaults and
// the Hamming encode/syndrome/extract helpers, sized by a runtime data width.
package dual_port_hamming_ram_pkg;

  localparam int DEF_WRITE_LATENCY = 1;
  localparam int DEF_READ_LATENCY  = 1;
  localparam int DEF_DATA_WIDTH    = 8;
  localparam int DEF_ADDRESS_DEPTH = 16;
  localparam int MAX_CW            = 64;

  function automatic int calc_parity_bits(input int dw);
    int p;
    p = 0;
    for (int i = 1; i < 16; i++)
      if (p == 0 && (1 << i) >= dw + i + 1) p = i;
    return p;
  endfunction

  localparam int P  = calc_parity_bits(DEF_DATA_WIDTH);
  localparam int CW = DEF_DATA_WIDTH + P;

  // Positions are 1-based; powers of two carry parity, the rest carry data LSB-first.
  function automatic logic [MAX_CW-1:0] hamming_encode(input logic [MAX_CW-1:0] data, input int dw);
    logic [MAX_CW-1:0] cw;
    int d;
    int n;
    cw = '0;
    d  = 0;
    n  = dw + calc_parity_bits(dw);
    for (int pos = 1; pos <= MAX_CW; pos++)
      if (pos <= n && (pos & (pos - 1)) != 0) begin
        cw[pos-1] = data[d];
        d++;
      end
    for (int i = 0; i < 7; i++)
      for (int pos = 1; pos <= MAX_CW; pos++)
        if (pos <= n && pos != (1 << i) && (pos & (1 << i)) != 0)
          cw[(1 << i) - 1] = cw[(1 << i) - 1] ^ cw[pos-1];
    return cw;
  endfunction

  function automatic int hamming_syndrome(input logic [MAX_CW-1:0] cw, input int n);
    int s;
    s = 0;
    for (int pos = 1; pos <= MAX_CW; pos++)
      if (pos <= n && cw[pos-1]) s = s ^ pos;
    return s;
  endfunction

  function automatic logic [MAX_CW-1:0] hamming_extract(input logic [MAX_CW-1:0] cw, input int dw);
    logic [MAX_CW-1:0] d;
    int k;
    int n;
    d = '0;
    k = 0;
    n = dw + calc_parity_bits(dw);
    for (int pos = 1; pos <= MAX_CW; pos++)
      if (pos <= n && (pos & (pos - 1)) != 0) begin
        d[k] = cw[pos-1];
        k++;
      end
    return d;
  endfunction

endpackage

// File: rtl/dual_port_hamming_ram_ram_port_pipe.sv
// One RAM port: encodes and delays writes to their commit edge, delays the
// registered array read and decodes/corrects it into the held output.
module ram_port_pipe
  import dual_port_hamming_ram_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int AW            = 4,
  parameter int CWID          = CW,
  parameter int WRITE_LATENCY = DEF_WRITE_LATENCY,
  parameter int READ_LATENCY  = DEF_READ_LATENCY
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic                  i_we,
  input  logic [AW-1:0]         i_addr,
  input  logic [DATA_WIDTH-1:0] i_din,
  input  logic [CWID-1:0]       i_flip,
  output logic                  o_wr_en,
  output logic [AW-1:0]         o_wr_addr,
  output logic [CWID-1:0]       o_wr_cw,
  input  logic [CWID-1:0]       i_rd_cw,
  output logic [DATA_WIDTH-1:0] o_dout,
  output logic                  o_err
);

  logic [CWID-1:0]       w_enc_cw;
  logic                  r_rd_vld_p0;
  logic                  w_rd_vld;
  logic [CWID-1:0]       w_rd_cw;
  logic [DATA_WIDTH-1:0] w_dec_data;
  logic                  w_dec_err;

  always_comb begin
    logic [MAX_CW-1:0] v_full;
    v_full   = hamming_encode(MAX_CW'(i_din), DATA_WIDTH);
    w_enc_cw = v_full[CWID-1:0] ^ i_flip;
  end

  // Write path: commit straight from the request or after WRITE_LATENCY-1 stages.
  if (WRITE_LATENCY == 1) begin : g_wr_direct
    assign o_wr_en   = i_en & i_we & ~i_rst;
    assign o_wr_addr = i_addr;
    assign o_wr_cw   = w_enc_cw;
  end else begin : g_wr_pipe
    localparam int WS = WRITE_LATENCY - 1;
    logic [WS-1:0]   r_wr_vld_p;
    logic [AW-1:0]   r_wr_addr_p [WS];
    logic [CWID-1:0] r_wr_cw_p   [WS];

    always_ff @(posedge i_clk) begin
      if (i_rst) r_wr_vld_p <= '0;
      else begin
        r_wr_vld_p[0] <= i_en & i_we;
        for (int i = 1; i < WS; i++) r_wr_vld_p[i] <= r_wr_vld_p[i-1];
      end
    end

    always_ff @(posedge i_clk) begin
      r_wr_addr_p[0] <= i_addr;
      r_wr_cw_p[0]   <= w_enc_cw;
      for (int i = 1; i < WS; i++) begin
        r_wr_addr_p[i] <= r_wr_addr_p[i-1];
        r_wr_cw_p[i]   <= r_wr_cw_p[i-1];
      end
    end

    assign o_wr_en   = r_wr_vld_p[WS-1] & ~i_rst;
    assign o_wr_addr = r_wr_addr_p[WS-1];
    assign o_wr_cw   = r_wr_cw_p[WS-1];
  end

  // Read path stage 0: the array word itself is registered in the top alongside this valid.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_rd_vld_p0 <= 1'b0;
    else       r_rd_vld_p0 <= i_en & ~i_we;
  end

  if (READ_LATENCY == 1) begin : g_rd_direct
    assign w_rd_vld = r_rd_vld_p0;
    assign w_rd_cw  = i_rd_cw;
  end else begin : g_rd_pipe
    localparam int RS = READ_LATENCY - 1;
    logic [RS-1:0]   r_rd_vld_p;
    logic [CWID-1:0] r_rd_cw_p [RS];

    always_ff @(posedge i_clk) begin
      if (i_rst) r_rd_vld_p <= '0;
      else begin
        r_rd_vld_p[0] <= r_rd_vld_p0;
        for (int i = 1; i < RS; i++) r_rd_vld_p[i] <= r_rd_vld_p[i-1];
      end
    end

    always_ff @(posedge i_clk) begin
      r_rd_cw_p[0] <= i_rd_cw;
      for (int i = 1; i < RS; i++) r_rd_cw_p[i] <= r_rd_cw_p[i-1];
    end

    assign w_rd_vld = r_rd_vld_p[RS-1];
    assign w_rd_cw  = r_rd_cw_p[RS-1];
  end

  // Decode stage: a syndrome beyond the codeword length is flagged but left uncorrected.
  always_comb begin
    logic [MAX_CW-1:0] v_cw;
    logic [MAX_CW-1:0] v_data;
    int                v_syn;
    v_cw  = MAX_CW'(w_rd_cw);
    v_syn = hamming_syndrome(v_cw, CWID);
    if (v_syn != 0 && v_syn <= CWID) v_cw = v_cw ^ (MAX_CW'(1) << (v_syn - 1));
    v_data     = hamming_extract(v_cw, DATA_WIDTH);
    w_dec_data = v_data[DATA_WIDTH-1:0];
    w_dec_err  = (v_syn != 0);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_dout <= '0;
      o_err  <= 1'b0;
    end else if (w_rd_vld) begin
      o_dout <= w_dec_data;
      o_err  <= w_dec_err;
    end
  end

endmodule

// File: rtl/dual_port_hamming_ram.sv
// Dual-port Hamming-protected RAM: two address-interleaved banks shared by
// two independent port pipelines; port A wins same-edge write collisions.
module dual_port_hamming_ram
  import dual_port_hamming_ram_pkg::*;
#(
  parameter int WRITE_LATENCY_A = DEF_WRITE_LATENCY,
  parameter int READ_LATENCY_A  = DEF_READ_LATENCY,
  parameter int WRITE_LATENCY_B = DEF_WRITE_LATENCY,
  parameter int READ_LATENCY_B  = DEF_READ_LATENCY,
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int ADDRESS_DEPTH   = DEF_ADDRESS_DEPTH,
  localparam int AW   = $clog2(ADDRESS_DEPTH),
  localparam int NPAR = calc_parity_bits(DATA_WIDTH),
  localparam int CWID = DATA_WIDTH + NPAR
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_ena,
  input  logic                  i_wea,
  input  logic [AW-1:0]         i_addra,
  input  logic [DATA_WIDTH-1:0] i_dina,
  input  logic [CWID-1:0]       i_flipa,
  output logic [DATA_WIDTH-1:0] o_douta,
  output logic                  o_erra,
  input  logic                  i_enb,
  input  logic                  i_web,
  input  logic [AW-1:0]         i_addrb,
  input  logic [DATA_WIDTH-1:0] i_dinb,
  input  logic [CWID-1:0]       i_flipb,
  output logic [DATA_WIDTH-1:0] o_doutb,
  output logic                  o_errb
);

  localparam int BD = ADDRESS_DEPTH / 2;
  localparam int IW = (AW > 1) ? AW - 1 : 1;

  logic [CWID-1:0] r_bank0 [BD];
  logic [CWID-1:0] r_bank1 [BD];
  logic            w_wr_en_a,   w_wr_en_b;
  logic [AW-1:0]   w_wr_addr_a, w_wr_addr_b;
  logic [CWID-1:0] w_wr_cw_a,   w_wr_cw_b;
  logic [CWID-1:0] r_rd_cw_a,   r_rd_cw_b;

  function automatic logic [IW-1:0] bank_idx(input logic [AW-1:0] a);
    return IW'(a >> 1);
  endfunction

  // Port B is written first so that port A's assignment lands last on a collision.
  always_ff @(posedge i_clk) begin
    if (w_wr_en_b && !w_wr_addr_b[0]) r_bank0[bank_idx(w_wr_addr_b)] <= w_wr_cw_b;
    if (w_wr_en_a && !w_wr_addr_a[0]) r_bank0[bank_idx(w_wr_addr_a)] <= w_wr_cw_a;
  end

  always_ff @(posedge i_clk) begin
    if (w_wr_en_b && w_wr_addr_b[0]) r_bank1[bank_idx(w_wr_addr_b)] <= w_wr_cw_b;
    if (w_wr_en_a && w_wr_addr_a[0]) r_bank1[bank_idx(w_wr_addr_a)] <= w_wr_cw_a;
  end

  // Array read stage: sampled before this edge's commits, giving read-first behaviour.
  always_ff @(posedge i_clk) begin
    if (i_ena && !i_wea)
      r_rd_cw_a <= i_addra[0] ? r_bank1[bank_idx(i_addra)] : r_bank0[bank_idx(i_addra)];
    if (i_enb && !i_web)
      r_rd_cw_b <= i_addrb[0] ? r_bank1[bank_idx(i_addrb)] : r_bank0[bank_idx(i_addrb)];
  end

  ram_port_pipe #(
    .DATA_WIDTH(DATA_WIDTH), .AW(AW), .CWID(CWID),
    .WRITE_LATENCY(WRITE_LATENCY_A), .READ_LATENCY(READ_LATENCY_A)
  ) u_pipe_a (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_ena), .i_we(i_wea), .i_addr(i_addra),
    .i_din(i_dina), .i_flip(i_flipa), .o_wr_en(w_wr_en_a), .o_wr_addr(w_wr_addr_a),
    .o_wr_cw(w_wr_cw_a), .i_rd_cw(r_rd_cw_a), .o_dout(o_douta), .o_err(o_erra)
  );

  ram_port_pipe #(
    .DATA_WIDTH(DATA_WIDTH), .AW(AW), .CWID(CWID),
    .WRITE_LATENCY(WRITE_LATENCY_B), .READ_LATENCY(READ_LATENCY_B)
  ) u_pipe_b (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_enb), .i_we(i_web), .i_addr(i_addrb),
    .i_din(i_dinb), .i_flip(i_flipb), .o_wr_en(w_wr_en_b), .o_wr_addr(w_wr_addr_b),
    .o_wr_cw(w_wr_cw_b), .i_rd_cw(r_rd_cw_b), .o_dout(o_doutb), .o_err(o_errb)
  );

endmodule

// File: tb/tb_dual_port_hamming_ram.sv
// Directed bench for dual_port_hamming_ram with a commit-accurate memory model
// and per-port scoreboards of expected read results keyed by due edge.
module tb_dual_port_hamming_ram;

  localparam int WLA = 3;
  localparam int RLA = 2;
  localparam int WLB = 1;
  localparam int RLB = 4;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_ena = 1'b0, i_wea = 1'b0, i_enb = 1'b0, i_web = 1'b0;
  logic [3:0]  i_addra = '0, i_addrb = '0;
  logic [7:0]  i_dina = '0, i_dinb = '0;
  logic [11:0] i_flipa = '0, i_flipb = '0;
  logic [7:0]  o_douta, o_doutb;
  logic        o_erra, o_errb;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  typedef struct { int due; logic [7:0] data; logic err; string tag; } exp_t;
  typedef struct { int cedge; bit port_b; logic [3:0] addr; logic [7:0] data; logic err; } wr_t;

  exp_t       qa[$];
  exp_t       qb[$];
  wr_t        pend[$];
  wr_t        keep[$];
  logic [7:0] mdata [16];
  logic       merr  [16];
  logic [7:0] last_d [2];
  logic       last_e [2];

  dual_port_hamming_ram #(
    .WRITE_LATENCY_A(WLA), .READ_LATENCY_A(RLA),
    .WRITE_LATENCY_B(WLB), .READ_LATENCY_B(RLB),
    .DATA_WIDTH(8), .ADDRESS_DEPTH(16)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_ena(i_ena), .i_wea(i_wea), .i_addra(i_addra), .i_dina(i_dina), .i_flipa(i_flipa),
    .o_douta(o_douta), .o_erra(o_erra),
    .i_enb(i_enb), .i_web(i_web), .i_addrb(i_addrb), .i_dinb(i_dinb), .i_flipb(i_flipb),
    .o_doutb(o_doutb), .o_errb(o_errb)
  );

  always #5 i_clk = ~i_clk;

  // Memory model: apply writes at their commit edge, B before A so A wins.
  always @(posedge i_clk) begin
    edge_n = edge_n + 1;
    foreach (pend[i])
      if (pend[i].cedge == edge_n && pend[i].port_b) begin
        mdata[pend[i].addr] = pend[i].data;
        merr[pend[i].addr]  = pend[i].err;
      end
    foreach (pend[i])
      if (pend[i].cedge == edge_n && !pend[i].port_b) begin
        mdata[pend[i].addr] = pend[i].data;
        merr[pend[i].addr]  = pend[i].err;
      end
    keep.delete();
    foreach (pend[i]) if (pend[i].cedge != edge_n) keep.push_back(pend[i]);
    pend = keep;
  end

  task automatic mon(input bit pb);
    logic [7:0] od;
    logic       oe;
    exp_t       e;
    bit         due;
    od  = pb ? o_doutb : o_douta;
    oe  = pb ? o_errb  : o_erra;
    due = 1'b0;
    if (pb) begin
      if (qb.size() > 0 && qb[0].due <= edge_n) begin e = qb.pop_front(); due = 1'b1; end
    end else begin
      if (qa.size() > 0 && qa[0].due <= edge_n) begin e = qa.pop_front(); due = 1'b1; end
    end
    checks++;
    if (due) begin
      assert (od === e.data && oe === e.err) else begin
        errors++;
        $error("FAIL %s port%s edge %0d: observed dout=%h err=%b, expected dout=%h err=%b",
               e.tag, pb ? "B" : "A", edge_n, od, oe, e.data, e.err);
      end
      last_d[pb] = e.data;
      last_e[pb] = e.err;
    end else begin
      assert (od === last_d[pb] && oe === last_e[pb]) else begin
        errors++;
        $error("FAIL hold port%s edge %0d: observed dout=%h err=%b, expected dout=%h err=%b",
               pb ? "B" : "A", edge_n, od, oe, last_d[pb], last_e[pb]);
      end
    end
  endtask

  always @(negedge i_clk) begin
    if (!i_rst) begin
      mon(1'b0);
      mon(1'b1);
    end
  end

  task automatic port_wr(input bit pb, input int a, input int d, input logic [11:0] f,
                         input int md, input logic me);
    wr_t w;
    w.cedge  = edge_n + (pb ? WLB : WLA);
    w.port_b = pb;
    w.addr   = 4'(a);
    w.data   = 8'(md);
    w.err    = me;
    pend.push_back(w);
    if (pb) begin i_enb = 1'b1; i_web = 1'b1; i_addrb = 4'(a); i_dinb = 8'(d); i_flipb = f; end
    else    begin i_ena = 1'b1; i_wea = 1'b1; i_addra = 4'(a); i_dina = 8'(d); i_flipa = f; end
  endtask

  task automatic wr(input bit pb, input int a, input int d);
    port_wr(pb, a, d, 12'h000, d, 1'b0);
  endtask

  task automatic rd(input bit pb, input int a, input string tag);
    exp_t e;
    e.data = mdata[4'(a)];
    e.err  = merr[4'(a)];
    e.tag  = tag;
    e.due  = edge_n + 1 + (pb ? RLB : RLA);
    if (pb) begin i_enb = 1'b1; i_web = 1'b0; i_addrb = 4'(a); qb.push_back(e); end
    else    begin i_ena = 1'b1; i_wea = 1'b0; i_addra = 4'(a); qa.push_back(e); end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
    i_ena = 1'b0; i_wea = 1'b0; i_flipa = '0;
    i_enb = 1'b0; i_web = 1'b0; i_flipb = '0;
  endtask

  task automatic do_reset(input int n);
    i_rst = 1'b1;
    i_ena = 1'b0; i_wea = 1'b0; i_enb = 1'b0; i_web = 1'b0;
    pend.delete();
    qa.delete();
    qb.delete();
    repeat (n) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    last_d[0] = '0; last_e[0] = 1'b0;
    last_d[1] = '0; last_e[1] = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    assert (o_douta === 8'h00 && o_erra === 1'b0) else begin
      errors++;
      $error("FAIL %s portA: observed dout=%h err=%b, expected dout=00 err=0", tag, o_douta, o_erra);
    end
    checks++;
    assert (o_doutb === 8'h00 && o_errb === 1'b0) else begin
      errors++;
      $error("FAIL %s portB: observed dout=%h err=%b, expected dout=00 err=0", tag, o_doutb, o_errb);
    end
  endtask

  initial begin
    do_reset(3);
    check_reset_outputs("reset_init");

    // Latency sweep: fill every address, then back-to-back reads on both ports.
    for (int i = 0; i < 16; i++) begin wr(1'b0, i, i); tick(); end
    repeat (WLA) tick();
    for (int i = 0; i < 16; i++) begin
      rd(1'b0, i, "sweep");
      rd(1'b1, 15 - i, "sweep");
      tick();
    end

    // Basic cross-port write/read, including the read that shares the commit edge.
    wr(1'b0, 3, 8'hA5); tick();
    tick();
    rd(1'b1, 3, "basic_readfirst"); tick();
    rd(1'b1, 3, "basic"); tick();

    // Error correction and detection.
    port_wr(1'b0, 5, 8'h3C, 12'h010, 8'h3C, 1'b1); tick();
    repeat (3) tick();
    rd(1'b0, 5, "corr_single"); tick();
    port_wr(1'b0, 7, 8'h3C, 12'h801, 8'hBC, 1'b1); tick();
    repeat (3) tick();
    rd(1'b0, 7, "corr_double"); tick();
    port_wr(1'b1, 8, 8'h5A, 12'h001, 8'h5A, 1'b1); tick();
    rd(1'b1, 8, "corr_parity"); tick();
    wr(1'b0, 5, 8'h3C); tick();
    repeat (3) tick();
    rd(1'b0, 5, "corr_clean"); tick();

    // Collision: both ports commit to address 6 on the same edge.
    wr(1'b0, 6, 8'h11); tick();
    tick();
    wr(1'b1, 6, 8'h22); tick();
    repeat (3) tick();
    rd(1'b0, 6, "coll_a_wins"); tick();
    wr(1'b1, 6, 8'h33);
    rd(1'b0, 6, "coll_readfirst"); tick();
    rd(1'b0, 6, "coll_new"); tick();

    // Banking: A reads even words while B writes odd words every cycle.
    for (int i = 0; i < 16; i++) begin
      rd(1'b0, (2 * i) % 16, "bank_even");
      wr(1'b1, (2 * i) % 16 + 1, 8'h80 + i);
      tick();
    end
    tick();
    for (int i = 0; i < 8; i++) begin
      rd(1'b0, 2 * i + 1, "bank_odd");
      rd(1'b1, 2 * i, "bank_even_b");
      tick();
    end
    repeat (6) tick();

    // Mid-stream reset with a pending port-A write and an in-flight port-B read.
    wr(1'b0, 9, 8'h77);
    rd(1'b1, 2, "inflight");
    tick();
    do_reset(2);
    check_reset_outputs("reset_mid");
    repeat (5) tick();
    rd(1'b0, 9, "post_reset"); tick();

    for (int i = 0; i < 20 && (qa.size() > 0 || qb.size() > 0); i++) tick();
    checks++;
    assert (qa.size() == 0 && qb.size() == 0) else begin
      errors++;
      $error("FAIL drain: observed %0d/%0d results outstanding, expected 0/0", qa.size(), qb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
